// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access unit.
// Exports: mem_state_t FSM encoding, alignment mask, wait-counter width.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        FAULT
    } mem_state_t;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
    localparam int         CNT_W           = 8;

endpackage

// File: rtl/dmem_access_unit_if.sv
// Data-memory bus handshake bundle (req/ack).
// master: req, we, addr, wdata out; ack, rdata in. slave: the reverse.
interface dmem_access_unit_if #(
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [DATA_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/wait_counter.sv
// Saturating 8-bit wait counter for bus request cycles.
// Ports: clk, reset (sync), clear, enable in; tc high when count == TIMEOUT-1.
module wait_counter
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != '1)) begin
            // saturate at all-ones so the count never wraps
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == LAST);
endmodule

// File: rtl/dmem_access_unit.sv
// Runs one req/ack bus transaction per load/store and stalls the core meanwhile.
// Ports: clk, reset, MemRead/MemWrite, ALUResult, WriteData in; ReadData, Stall, MemFault out; bus master.
module dmem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              MemFault,
    dmem_access_unit_if.master bus
);
    mem_state_t        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fault_q, fault_d;

    logic access;
    logic aligned;
    logic cnt_clr;
    logic cnt_en;
    logic cnt_tc;

    assign access  = MemRead | MemWrite;
    assign aligned = ((ALUResult[1:0] & WORD_ALIGN_MASK) == 2'b00);

    wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .tc     (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access && aligned) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = MemWrite;
                    addr_d  = ALUResult;
                    wdata_d = WriteData;
                    cnt_clr = 1'b1;
                end else if (access) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    rdata_d = '0;
                end
            end
            REQ: begin
                if (bus.bus_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = bus.bus_rdata;
                    end
                end else if (cnt_tc) begin
                    state_d = FAULT;
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            // the instruction commits here; returning to IDLE first
            // keeps the held MemRead/MemWrite from relaunching
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign Stall = ((state_q == IDLE) && access) || (state_q == REQ);

    assign ReadData      = rdata_q;
    assign MemFault      = fault_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: per-cycle plan built from
// transaction latency rules, applied to the DUT and compared every cycle.
module tb_dmem_access_unit;
    import mem_pkg::*;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        MemFault;

    dmem_access_unit_if #(.DATA_W(32)) bus_if ();

    dmem_access_unit #(
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .MemFault  (MemFault),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        mr;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic        ack;
        logic [31:0] rdat;
        bit          chk;
        bit          chk_bus;
        logic        e_stall;
        logic        e_req;
        logic        e_fault;
        logic        e_we;
        logic [31:0] e_rd;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
    } cyc_t;

    cyc_t        plan[$];
    cyc_t        exp_q[$];
    logic [31:0] rd_model;
    int          errors;
    int          checks;

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic cyc_t blank();
        cyc_t c;
        c.rst     = 1'b0;
        c.mr      = 1'b0;
        c.mw      = 1'b0;
        c.alu     = $urandom();
        c.wd      = $urandom();
        c.ack     = 1'($urandom_range(0, 1));
        c.rdat    = $urandom();
        c.chk     = 1'b1;
        c.chk_bus = 1'b0;
        c.e_stall = 1'b0;
        c.e_req   = 1'b0;
        c.e_fault = 1'b0;
        c.e_we    = 1'b0;
        c.e_rd    = rd_model;
        c.e_addr  = '0;
        c.e_wd    = '0;
        return c;
    endfunction

    task automatic add_idle();
        plan.push_back(blank());
    endtask

    // Whole instruction timeline: issue cycle, then either FAULT, or
    // min(w+1, TO) request cycles followed by DONE (ack) or FAULT (timeout).
    task automatic add_instr(bit mr, bit mw, logic [31:0] a,
                             logic [31:0] wd, int w, logic [31:0] rdat);
        cyc_t c;
        int   n;
        c = blank();
        c.mr = mr; c.mw = mw; c.alu = a; c.wd = wd;
        c.e_stall = 1'b1;
        plan.push_back(c);
        if (a[1:0] != 2'b00) begin
            rd_model = '0;
            c = blank();
            c.mr = mr; c.mw = mw; c.alu = a; c.wd = wd;
            c.e_fault = 1'b1;
            plan.push_back(c);
            return;
        end
        n = (w < TO) ? w + 1 : TO;
        for (int j = 0; j < n; j++) begin
            c = blank();
            c.mr = mr; c.mw = mw; c.alu = a; c.wd = wd;
            c.ack = (j == w);
            if (j == w) c.rdat = rdat;
            c.e_stall = 1'b1;
            c.e_req   = 1'b1;
            c.chk_bus = 1'b1;
            c.e_we    = mw;
            c.e_addr  = a;
            c.e_wd    = wd;
            plan.push_back(c);
        end
        if (w < TO) begin
            if (!mw) rd_model = rdat;
            c = blank();
            c.mr = mr; c.mw = mw; c.alu = a; c.wd = wd;
        end else begin
            rd_model = '0;
            c = blank();
            c.mr = mr; c.mw = mw; c.alu = a; c.wd = wd;
            c.e_fault = 1'b1;
        end
        plan.push_back(c);
    endtask

    // Reset asserted during the second request cycle, late ack afterwards.
    task automatic add_reset_mid(logic [31:0] a);
        cyc_t c;
        for (int j = 0; j < 3; j++) begin
            c = blank();
            c.mr = 1'b1; c.alu = a; c.ack = 1'b0;
            c.e_stall = 1'b1;
            if (j > 0) begin
                c.e_req   = 1'b1;
                c.chk_bus = 1'b1;
                c.e_addr  = a;
                c.e_wd    = c.wd;
            end
            if (j == 1) c.e_wd = plan[plan.size()-1].wd;
            if (j == 2) begin
                c.wd   = plan[plan.size()-1].wd;
                c.e_wd = c.wd;
                c.rst  = 1'b1;
            end
            if (j == 1) c.wd = c.e_wd;
            plan.push_back(c);
        end
        rd_model = '0;
        c = blank();
        c.ack = 1'b1;
        c.e_rd = '0;
        c.chk_bus = 1'b1;
        plan.push_back(c);
        c = blank();
        c.ack = 1'b1;
        plan.push_back(c);
    endtask

    always @(negedge clk) begin
        cyc_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                check("stall", 32'(Stall), 32'(e.e_stall));
                check("bus_req", 32'(bus_if.bus_req), 32'(e.e_req));
                check("mem_fault", 32'(MemFault), 32'(e.e_fault));
                check("read_data", ReadData, e.e_rd);
                if (e.chk_bus) begin
                    check("bus_we", 32'(bus_if.bus_we), 32'(e.e_we));
                    check("bus_addr", bus_if.bus_addr, e.e_addr);
                    check("bus_wdata", bus_if.bus_wdata, e.e_wd);
                end
            end
        end
    end

    initial begin
        cyc_t c;
        int   n0;
        int   nreq;
        errors    = 0;
        checks    = 0;
        rd_model  = '0;
        reset     = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        ALUResult = '0;
        WriteData = '0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = '0;

        c = blank(); c.rst = 1'b1; c.chk = 1'b0;
        plan.push_back(c);
        c = blank(); c.rst = 1'b1; c.chk_bus = 1'b1;
        plan.push_back(c);
        add_idle();
        add_idle();

        n0 = plan.size();
        add_instr(1, 0, 32'h40, 32'h0, 0, 32'hDEADBEEF);
        check("pin_load_len", plan.size() - n0, 3);
        check("pin_load_stall", {plan[n0].e_stall, plan[n0+1].e_stall,
                                 plan[n0+2].e_stall}, 3'b110);
        check("pin_load_rd", rd_model, 32'hDEADBEEF);
        add_idle();

        n0 = plan.size();
        add_instr(0, 1, 32'h80, 32'h12345678, 3, 32'h0BAD0BAD);
        nreq = 0;
        for (int i = n0; i < plan.size(); i++) nreq += int'(plan[i].e_req);
        check("pin_store_len", plan.size() - n0, 6);
        check("pin_store_req", nreq, 4);
        check("pin_store_rd", rd_model, 32'hDEADBEEF);
        add_idle();

        n0 = plan.size();
        add_instr(1, 0, 32'h43, 32'h0, 0, 32'h1);
        check("pin_misal_len", plan.size() - n0, 2);
        check("pin_misal_rd", rd_model, 32'h0);
        add_idle();

        n0 = plan.size();
        add_instr(1, 0, 32'h10, 32'h0, 99, 32'h0);
        nreq = 0;
        for (int i = n0; i < plan.size(); i++) nreq += int'(plan[i].e_req);
        check("pin_timeout_req", nreq, 4);
        check("pin_timeout_fault", 32'(plan[plan.size()-1].e_fault), 1);
        add_idle();

        add_instr(1, 0, 32'h20, 32'h0, 0, 32'hCAFEF00D);
        add_reset_mid(32'h24);

        add_instr(1, 0, 32'h0, 32'h0, 0, 32'h11111111);
        add_instr(1, 0, 32'h4, 32'h0, 0, 32'h22222222);
        add_idle();

        for (int k = 0; k < 200; k++) begin
            logic [31:0] a;
            int          op;
            a = $urandom();
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            op = $urandom_range(0, 2);
            add_instr(op != 1, op != 0, a, $urandom(),
                      $urandom_range(0, 5), $urandom());
            for (int g = $urandom_range(0, 2); g > 0; g--) add_idle();
        end

        @(posedge clk);
        #1;
        foreach (plan[i]) begin
            reset            = plan[i].rst;
            MemRead          = plan[i].mr;
            MemWrite         = plan[i].mw;
            ALUResult        = plan[i].alu;
            WriteData        = plan[i].wd;
            bus_if.bus_ack   = plan[i].ack;
            bus_if.bus_rdata = plan[i].rdat;
            exp_q.push_back(plan[i]);
            @(posedge clk);
            #1;
        end
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
